// File: rtl/clb_pkg.sv
// +--------------------------------------------------------------------+
// | clb_pkg: shared types and constants for the CLB pair packer.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package clb_pkg;

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_HALF  = 1'b1
   } pack_state_t;

   localparam int CLB_PACK_FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/clb_pair_fifo.sv
// +--------------------------------------------------------------------+
// | clb_pair_fifo: 2-entry head+skid buffer with push/pop/count.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module clb_pair_fifo
   import clb_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] head,
   output logic [1:0]    count,
   output logic          vld
);

   localparam logic [1:0] FULL = 2'(CLB_PACK_FIFO_DEPTH);

   logic [DW-1:0] head_q;
   logic [DW-1:0] skid_q;
   logic [1:0]    count_q;
   logic          pop_ok;
   logic          push_ok;

   assign pop_ok  = pop & (count_q != 2'd0);
   assign push_ok = push & ((count_q != FULL) | pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         skid_q  <= '0;
         count_q <= 2'd0;
      end else if (push_ok && pop_ok) begin
         // Count unchanged; the older skid entry moves forward first.
         if (count_q == FULL) begin
            head_q <= skid_q;
            skid_q <= din;
         end else begin
            head_q <= din;
         end
      end else if (push_ok) begin
         if (count_q == 2'd0) head_q <= din;
         else                 skid_q <= din;
         count_q <= count_q + 2'd1;
      end else if (pop_ok) begin
         if (count_q == FULL) head_q <= skid_q;
         count_q <= count_q - 2'd1;
      end
   end

   assign head  = head_q;
   assign count = count_q;
   assign vld   = (count_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/clb_pair_packer.sv
// +--------------------------------------------------------------------+
// | clb_pair_packer: packs word pairs into 2*WIDTH operands, 2-deep buf.|
// | Optional flush port via CLB_PACK_FLUSH_EN.  Revision: 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module clb_pair_packer
   import clb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [WIDTH-1:0]   din,
   input  logic               divld,
   output logic               rdy,
   output logic [2*WIDTH-1:0] dout,
   output logic               dovld,
   input  logic               dsrdy,
`ifdef CLB_PACK_FLUSH_EN
   input  logic               flush,
`endif
   output logic [CNTW-1:0]    pair_cnt
);

   localparam logic [1:0] FULL = 2'(CLB_PACK_FIFO_DEPTH);

   pack_state_t        state;
   pack_state_t        state_nxt;
   logic [WIDTH-1:0]   held;
   logic [CNTW-1:0]    cnt_q;
   logic [1:0]         fifo_count;
   logic               accept;
   logic               pop;
   logic               push;
   logic               load_held;
   logic [2*WIDTH-1:0] push_data;
`ifdef CLB_PACK_FLUSH_EN
   logic               do_flush;
`endif

   // rdy uses the pre-pop count so there is no path from dsrdy to rdy.
   assign rdy    = en & ~rst & ((state == S_EMPTY) | (fifo_count != FULL));
   assign accept = en & divld & rdy;
   assign pop    = en & dovld & dsrdy;

`ifdef CLB_PACK_FLUSH_EN
   assign do_flush = en & flush & (fifo_count != FULL) & ~divld;
`endif

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      load_held = 1'b0;
      push_data = {din, held};
      case (state)
         S_EMPTY: begin
            if (accept) begin
               load_held = 1'b1;
               state_nxt = S_HALF;
            end
         end
         S_HALF: begin
            if (accept) begin
               push      = 1'b1;
               state_nxt = S_EMPTY;
            end
`ifdef CLB_PACK_FLUSH_EN
            else if (do_flush) begin
               push      = 1'b1;
               push_data = {{WIDTH{1'b0}}, held};
               state_nxt = S_EMPTY;
            end
`endif
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_EMPTY;
         held  <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_held) held  <= din;
         if (pop)       cnt_q <= cnt_q + CNTW'(1);
      end
   end

   clb_pair_fifo #(
      .DW (2*WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .head  (dout),
      .count (fifo_count),
      .vld   (dovld)
   );

   assign pair_cnt = cnt_q;

endmodule

`default_nettype wire
